td4x_core: RTL

//  Parametrised next-generation TD4-style accumulator CPU core. It fetches one

---
 rtl/td4x_core.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/td4x_core.sv
// -----------------------------------------------------------------------------
// td4x_core
//   TD4-style accumulator CPU core with a req/ack instruction fetch port.
//   The core fetches one instruction per handshake, then executes it in a
//   single cycle. It keeps A/B registers plus carry and zero flags, and it
//   drives a latched LED output port with a write strobe. The instruction
//   set adds SUB, JZ, OUT A and HALT/resume to the original TD4 set.
//
// Parameters
//   DATA_W  width of A, B, LED, switch port and immediate (must be >= ADDR_W)
//   ADDR_W  width of the instruction pointer / fetch address
//
// Ports
//   i_clock        rising-edge clock
//   i_reset_n      asynchronous active-low reset
//   o_fetch_req    fetch request, held until i_fetch_ack
//   o_fetch_addr   fetch address (= IP), stable while o_fetch_req is high
//   i_fetch_ack    i_fetch_data is valid this cycle (ignored unless requesting)
//   i_fetch_data   instruction word: {opcode[3:0], imm[DATA_W-1:0]}
//   i_switch       input port, read by IN A / IN B
//   i_resume       level input that leaves the HALT state
//   o_led          output port register
//   o_led_strobe   one-cycle pulse in the cycle after an OUT instruction
//   o_halted       high while the core is in the HALT state
// -----------------------------------------------------------------------------
module td4x_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    output logic                o_fetch_req,
    output logic [ADDR_W-1:0]   o_fetch_addr,
    input  logic                i_fetch_ack,
    input  logic [DATA_W+3:0]   i_fetch_data,
    input  logic [DATA_W-1:0]   i_switch,
    input  logic                i_resume,
    output logic [DATA_W-1:0]   o_led,
    output logic                o_led_strobe,
    output logic                o_halted
);

    localparam int INSTR_W = 4 + DATA_W;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [ADDR_W-1:0]   r_ip;
    logic                r_cf;
    logic                r_zf;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_led;
    logic                r_led_strobe;
    logic                r_halted;
    logic                r_fetch_req;

    // Instruction decode fields
    logic [3:0]          w_opcode;
    logic [DATA_W-1:0]   w_imm;
    logic [ADDR_W-1:0]   w_target;
    logic [ADDR_W-1:0]   w_ip_inc;

    // Arithmetic results carry one extra bit: carry-out for ADD, borrow for SUB
    logic [DATA_W:0]     w_add_a;
    logic [DATA_W:0]     w_add_b;
    logic [DATA_W:0]     w_sub_a;

    assign w_opcode = r_ir[INSTR_W-1 -: 4];
    assign w_imm    = r_ir[DATA_W-1:0];
    assign w_target = w_imm[ADDR_W-1:0];
    assign w_ip_inc = r_ip + ADDR_W'(1);

    assign w_add_a  = {1'b0, r_a} + {1'b0, w_imm};
    assign w_add_b  = {1'b0, r_b} + {1'b0, w_imm};
    assign w_sub_a  = {1'b0, r_a} - {1'b0, w_imm};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_FETCH;
            r_a          <= '0;
            r_b          <= '0;
            r_ip         <= '0;
            r_cf         <= 1'b0;
            r_zf         <= 1'b0;
            r_ir         <= '0;
            r_led        <= '0;
            r_led_strobe <= 1'b0;
            r_halted     <= 1'b0;
            r_fetch_req  <= 1'b0;
        end else begin
            r_led_strobe <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    // Only an ack seen while the request is already out counts;
                    // a stale ack held across reset release is ignored here.
                    if (r_fetch_req && i_fetch_ack) begin
                        r_ir        <= i_fetch_data;
                        r_fetch_req <= 1'b0;
                        r_state     <= ST_EXEC;
                    end else begin
                        r_fetch_req <= 1'b1;
                    end
                end

                ST_EXEC: begin
                    // Defaults: fall through to next word, flags cleared.
                    // Branches below read r_cf/r_zf before these take effect.
                    r_ip    <= w_ip_inc;
                    r_cf    <= 1'b0;
                    r_zf    <= 1'b0;
                    r_state <= ST_FETCH;
                    case (w_opcode)
                        4'b0000: begin  // ADD A,imm
                            r_a  <= w_add_a[DATA_W-1:0];
                            r_cf <= w_add_a[DATA_W];
                            r_zf <= (w_add_a[DATA_W-1:0] == '0);
                        end
                        4'b0101: begin  // ADD B,imm
                            r_b  <= w_add_b[DATA_W-1:0];
                            r_cf <= w_add_b[DATA_W];
                            r_zf <= (w_add_b[DATA_W-1:0] == '0);
                        end
                        4'b1000: begin  // SUB A,imm (cf = borrow)
                            r_a  <= w_sub_a[DATA_W-1:0];
                            r_cf <= w_sub_a[DATA_W];
                            r_zf <= (w_sub_a[DATA_W-1:0] == '0);
                        end
                        4'b0011: r_a <= w_imm;       // MOV A,imm
                        4'b0111: r_b <= w_imm;       // MOV B,imm
                        4'b0001: r_a <= r_b;         // MOV A,B
                        4'b0100: r_b <= r_a;         // MOV B,A
                        4'b0010: r_a <= i_switch;    // IN A
                        4'b0110: r_b <= i_switch;    // IN B
                        4'b1111: r_ip <= w_target;   // JMP
                        4'b1110: if (!r_cf) r_ip <= w_target;  // JNC
                        4'b1010: if (r_zf)  r_ip <= w_target;  // JZ
                        4'b1001: begin  // OUT B
                            r_led        <= r_b;
                            r_led_strobe <= 1'b1;
                        end
                        4'b1011: begin  // OUT imm
                            r_led        <= w_imm;
                            r_led_strobe <= 1'b1;
                        end
                        4'b1101: begin  // OUT A
                            r_led        <= r_a;
                            r_led_strobe <= 1'b1;
                        end
                        4'b1100: begin  // HALT: IP already advanced to next word
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    endcase
                end

                ST_HALT: begin
                    if (i_resume) begin
                        r_state  <= ST_FETCH;
                        r_halted <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign o_fetch_req  = r_fetch_req;
    assign o_fetch_addr = r_ip;
    assign o_led        = r_led;
    assign o_led_strobe = r_led_strobe;
    assign o_halted     = r_halted;

endmodule
